dmem_banked_ctrl: RTL and testbench

Parametrised data memory with a valid/ready request port, byte/half/word access sizes with sign or zero extension, configurable wait states and error reporting. It replaces the fixed-size word-only data memory in the processor's memory stage. Every access, read or write, passes through one small state machine that controls response timing. Memory contents are not reset; control state is.

---
 rtl/dmem_pkg.sv | 20 ++
 rtl/dmem_banked_ctrl_if.sv | 26 ++
 rtl/dmem_lane_align.sv | 44 ++++
 rtl/dmem_banked_ctrl.sv | 131 +++++++++++++
 tb/tb_dmem_banked_ctrl.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the banked data memory controller:
// access-size encodings, controller state encoding and wait-counter width.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        RESP = 2'b10
    } state_e;

    localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/dmem_banked_ctrl_if.sv
// Request/response bundle of the data memory: valid/ready request side
// plus a one-cycle response strobe with no backpressure.
interface dmem_banked_ctrl_if #(
    parameter int ADDR_W = 32
) ();
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for the data memory: merges store data into the
// addressed word and extracts/extends load data. Half and word accesses
// ignore the low offset bits that would make them misaligned.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [31:0] i_old_word,
    input  logic [31:0] i_wdata,
    input  size_e       i_size,
    input  logic [1:0]  i_off,
    input  logic        i_unsigned,
    output logic [31:0] o_new_word,
    output logic [31:0] o_load_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_old_word[{i_off, 3'b000} +: 8];
    assign w_half = i_old_word[{i_off[1], 4'b0000} +: 16];

    // Store merge: replace only the addressed lanes, keep the rest.
    always_comb begin
        o_new_word = i_old_word;
        case (i_size)
            SZ_BYTE: o_new_word[{i_off, 3'b000} +: 8]    = i_wdata[7:0];
            SZ_HALF: o_new_word[{i_off[1], 4'b0000} +: 16] = i_wdata[15:0];
            SZ_WORD: o_new_word = i_wdata;
            default: o_new_word = i_old_word;
        endcase
    end

    // Load extract: pick the same lanes a store would touch, then extend.
    always_comb begin
        o_load_data = 32'h0;
        case (i_size)
            SZ_BYTE: o_load_data = i_unsigned ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
            SZ_HALF: o_load_data = i_unsigned ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
            SZ_WORD: o_load_data = i_old_word;
            default: o_load_data = 32'h0;
        endcase
    end

endmodule

// File: rtl/dmem_banked_ctrl.sv
// Parametrised data memory with a valid/ready request port, byte/half/word
// accesses, programmable wait states and error reporting.
// Optional build macro: DMEM_ALIGN_CHECK_EN -- when defined, misaligned half
// and word accesses are rejected; otherwise they are force-aligned.
module dmem_banked_ctrl
    import dmem_pkg::*;
#(
    parameter int DEPTH       = 32,
    parameter int WAIT_CYCLES = 0,
    parameter int ADDR_W      = 32
) (
    input  logic clk,
    input  logic rst,
    dmem_banked_ctrl_if.slave bus
);

    localparam int              IDX_W     = $clog2(DEPTH);
    localparam logic [ADDR_W:0] MEM_BYTES = (ADDR_W+1)'(4 * DEPTH);

    state_e                r_state;
    logic [WAIT_CNT_W-1:0] r_cnt;
    logic                  r_ready;
    logic                  r_we;
    logic                  r_unsigned;
    size_e                 r_size;
    logic [ADDR_W-1:0]     r_addr;
    logic [31:0]           r_wdata;
    logic                  r_rsp_valid;
    logic [31:0]           r_rdata;
    logic                  r_err;
    logic [31:0]           r_mem [DEPTH];

    logic [IDX_W-1:0] w_idx;
    logic [31:0]      w_old_word;
    logic [31:0]      w_new_word;
    logic [31:0]      w_load_data;
    logic             w_range_err;
    logic             w_size_err;
    logic             w_align_err;
    logic             w_err;
    logic             w_access;

    assign w_idx       = r_addr[IDX_W+1:2];
    assign w_old_word  = r_mem[w_idx];
    assign w_range_err = {1'b0, r_addr} >= MEM_BYTES;
    assign w_size_err  = (r_size == SZ_RSVD);
`ifdef DMEM_ALIGN_CHECK_EN
    assign w_align_err = ((r_size == SZ_HALF) && r_addr[0]) ||
                         ((r_size == SZ_WORD) && (r_addr[1:0] != 2'b00));
`else
    assign w_align_err = 1'b0;
`endif
    assign w_err       = w_range_err || w_size_err || w_align_err;
    assign w_access    = (r_state == BUSY) && (r_cnt == '0);

    dmem_lane_align u_lane_align (
        .i_old_word  (w_old_word),
        .i_wdata     (r_wdata),
        .i_size      (r_size),
        .i_off       (r_addr[1:0]),
        .i_unsigned  (r_unsigned),
        .o_new_word  (w_new_word),
        .o_load_data (w_load_data)
    );

    // Ready is masked by rst so it reads low for the whole reset window.
    assign bus.req_ready = r_ready && !rst;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rdata;
    assign bus.rsp_err   = r_err;

    // Controller: accept, count wait states, access, then one response cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_ready     <= 1'b1;
            r_we        <= 1'b0;
            r_unsigned  <= 1'b0;
            r_size      <= SZ_BYTE;
            r_addr      <= '0;
            r_wdata     <= 32'h0;
            r_rsp_valid <= 1'b0;
            r_rdata     <= 32'h0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.req_valid) begin
                        r_we       <= bus.req_we;
                        r_size     <= size_e'(bus.req_size);
                        r_unsigned <= bus.req_unsigned;
                        r_addr     <= bus.req_addr;
                        r_wdata    <= bus.req_wdata;
                        r_cnt      <= WAIT_CNT_W'(WAIT_CYCLES);
                        r_ready    <= 1'b0;
                        r_state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_rsp_valid <= 1'b1;
                        r_err       <= w_err;
                        r_rdata     <= (w_err || r_we) ? 32'h0 : w_load_data;
                        r_state     <= RESP;
                    end
                end
                RESP: begin
                    r_rsp_valid <= 1'b0;
                    r_ready     <= 1'b1;
                    r_state     <= IDLE;
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                    r_ready     <= 1'b1;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    // Array write happens only on the access edge of an error-free store.
    always_ff @(posedge clk) begin
        if (!rst && w_access && r_we && !w_err) begin
            r_mem[w_idx] <= w_new_word;
        end
    end

endmodule

// File: tb/tb_dmem_banked_ctrl.sv
// Bench for dmem_banked_ctrl: two instances (0 and 3 wait states) checked
// against a byte-array reference model with directed and random accesses.
module tb_dmem_banked_ctrl;

    localparam int DEPTH = 32;
    localparam int AW    = 32;
    localparam int NBYTE = 4 * DEPTH;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dmem_banked_ctrl_if #(.ADDR_W(AW)) bus0 ();
    dmem_banked_ctrl_if #(.ADDR_W(AW)) bus3 ();

    dmem_banked_ctrl #(.DEPTH(DEPTH), .WAIT_CYCLES(0), .ADDR_W(AW)) u_dut0 (
        .clk (clk), .rst (rst), .bus (bus0.slave));
    dmem_banked_ctrl #(.DEPTH(DEPTH), .WAIT_CYCLES(3), .ADDR_W(AW)) u_dut3 (
        .clk (clk), .rst (rst), .bus (bus3.slave));

    logic        t_valid [2];
    logic        t_we    [2];
    logic [1:0]  t_size  [2];
    logic        t_uns   [2];
    logic [31:0] t_addr  [2];
    logic [31:0] t_wdata [2];
    logic        o_ready [2];
    logic        o_rvld  [2];
    logic [31:0] o_rdata [2];
    logic        o_err   [2];

    assign bus0.req_valid = t_valid[0];  assign bus3.req_valid = t_valid[1];
    assign bus0.req_we    = t_we[0];     assign bus3.req_we    = t_we[1];
    assign bus0.req_size  = t_size[0];   assign bus3.req_size  = t_size[1];
    assign bus0.req_unsigned = t_uns[0]; assign bus3.req_unsigned = t_uns[1];
    assign bus0.req_addr  = t_addr[0];   assign bus3.req_addr  = t_addr[1];
    assign bus0.req_wdata = t_wdata[0];  assign bus3.req_wdata = t_wdata[1];
    assign o_ready[0] = bus0.req_ready;  assign o_ready[1] = bus3.req_ready;
    assign o_rvld[0]  = bus0.rsp_valid;  assign o_rvld[1]  = bus3.rsp_valid;
    assign o_rdata[0] = bus0.rsp_rdata;  assign o_rdata[1] = bus3.rsp_rdata;
    assign o_err[0]   = bus0.rsp_err;    assign o_err[1]   = bus3.rsp_err;

    int checks   = 0;
    int failures = 0;

    logic [7:0] mm [2][NBYTE];

    function automatic int wait_of(input int sel);
        return (sel == 0) ? 0 : 3;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: byte-addressed memory, accesses rounded down to their size.
    task automatic model(input int sel, input bit we, input bit [1:0] sz, input bit uns,
                         input logic [31:0] addr, input logic [31:0] wd,
                         output logic [31:0] rd, output bit er);
        int unsigned n, base;
        logic [31:0] val, mask;
        n  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        er = (addr >= NBYTE) || (sz == 2'd3);
`ifdef DMEM_ALIGN_CHECK_EN
        if (addr % n != 0) er = 1'b1;
`endif
        rd = 32'h0;
        if (er) return;
        base = addr - (addr % n);
        if (we) begin
            for (int i = 0; i < int'(n); i++) mm[sel][base + i] = wd[8*i +: 8];
        end else begin
            val = 32'h0;
            for (int i = 0; i < int'(n); i++) val = val | (32'(mm[sel][base + i]) << (8*i));
            if (n < 4) begin
                mask = (32'h1 << (8*n)) - 32'h1;
                if (!uns && val[8*n-1]) val = val | ~mask;
            end
            rd = val;
        end
    endtask

    // One full transaction with timing checks; optionally waves junk
    // request fields while the access is in flight.
    task automatic do_access(input int sel, input bit we, input bit [1:0] sz, input bit uns,
                             input logic [31:0] addr, input logic [31:0] wd, input bit junk,
                             output logic [31:0] obs_rd, output logic obs_er);
        int waitc, lat;
        logic [31:0] erd;
        bit eer;
        waitc = 0;
        while (o_ready[sel] !== 1'b1 && waitc < 20) begin
            @(posedge clk); #1; waitc++;
        end
        chk("ready_before_req", 32'(o_ready[sel]), 32'd1);
        t_valid[sel] = 1'b1; t_we[sel] = we; t_size[sel] = sz; t_uns[sel] = uns;
        t_addr[sel] = addr; t_wdata[sel] = wd;
        @(posedge clk); #1;
        if (junk) begin
            t_we[sel] = 1'($urandom); t_size[sel] = 2'($urandom); t_uns[sel] = 1'($urandom);
            t_addr[sel] = 32'($urandom_range(0, NBYTE - 1)); t_wdata[sel] = $urandom;
        end else begin
            t_valid[sel] = 1'b0;
        end
        lat = 0;
        while (o_rvld[sel] !== 1'b1 && lat < 40) begin
            chk("ready_low_busy", 32'(o_ready[sel]), 32'd0);
            @(posedge clk); #1; lat++;
        end
        t_valid[sel] = 1'b0;
        chk("rsp_latency", 32'(lat), 32'(wait_of(sel) + 1));
        model(sel, we, sz, uns, addr, wd, erd, eer);
        obs_rd = o_rdata[sel];
        obs_er = o_err[sel];
        chk("rsp_rdata", obs_rd, erd);
        chk("rsp_err", 32'(obs_er), 32'(eer));
        chk("ready_low_resp", 32'(o_ready[sel]), 32'd0);
        @(posedge clk); #1;
        chk("rsp_one_cycle", 32'(o_rvld[sel]), 32'd0);
        chk("ready_back", 32'(o_ready[sel]), 32'd1);
    endtask

    initial begin
        logic [31:0] rd;
        logic er;
        logic [31:0] keep0;
        for (int s = 0; s < 2; s++) begin
            t_valid[s] = 0; t_we[s] = 0; t_size[s] = 0; t_uns[s] = 0; t_addr[s] = 0; t_wdata[s] = 0;
        end

        // Reset values
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            chk("rst_rsp_valid", 32'(o_rvld[s]), 32'd0);
            chk("rst_rdata", o_rdata[s], 32'h0);
            chk("rst_err", 32'(o_err[s]), 32'd0);
            chk("rst_ready_low", 32'(o_ready[s]), 32'd0);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        for (int s = 0; s < 2; s++) chk("ready_after_rst", 32'(o_ready[s]), 32'd1);

        // Fill both arrays so every word is known to the model
        for (int w = 0; w < DEPTH; w++)
            for (int s = 0; s < 2; s++)
                do_access(s, 1'b1, 2'd2, 1'b0, 32'(4*w), $urandom, 1'b0, rd, er);

        // Word store/load round trip with zero wait states
        do_access(0, 1'b1, 2'd2, 1'b0, 32'h8, 32'hDEADBEEF, 1'b0, rd, er);
        do_access(0, 1'b0, 2'd2, 1'b0, 32'h8, 32'h0, 1'b0, rd, er);
        chk("tp_word_load", rd, 32'hDEADBEEF);
        chk("tp_word_err", 32'(er), 32'd0);

        // Byte merge and sign/zero extension
        do_access(0, 1'b1, 2'd2, 1'b0, 32'h8, 32'h11223344, 1'b0, rd, er);
        do_access(0, 1'b1, 2'd0, 1'b0, 32'h9, 32'h00000080, 1'b0, rd, er);
        do_access(0, 1'b0, 2'd2, 1'b0, 32'h8, 32'h0, 1'b0, rd, er);
        chk("tp_byte_merge", rd, 32'h11228044);
        do_access(0, 1'b0, 2'd0, 1'b0, 32'h9, 32'h0, 1'b0, rd, er);
        chk("tp_byte_signed", rd, 32'hFFFFFF80);
        do_access(0, 1'b0, 2'd0, 1'b1, 32'h9, 32'h0, 1'b0, rd, er);
        chk("tp_byte_unsigned", rd, 32'h00000080);
        do_access(0, 1'b0, 2'd1, 1'b0, 32'hA, 32'h0, 1'b0, rd, er);
        chk("tp_half_signed", rd, 32'h00001122);

        // Range and reserved-size errors
        do_access(0, 1'b0, 2'd2, 1'b0, 32'(NBYTE), 32'h0, 1'b0, rd, er);
        chk("tp_range_err", 32'(er), 32'd1);
        chk("tp_range_rdata", rd, 32'h0);
        do_access(0, 1'b1, 2'd2, 1'b0, 32'h10, 32'h55AA55AA, 1'b0, rd, er);
        do_access(0, 1'b1, 2'd3, 1'b0, 32'h10, 32'hFFFFFFFF, 1'b0, rd, er);
        chk("tp_size_err", 32'(er), 32'd1);
        do_access(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0, rd, er);
        chk("tp_size_nowrite", rd, 32'h55AA55AA);

        // Misaligned word store
        do_access(0, 1'b1, 2'd2, 1'b0, 32'h4, 32'h01020304, 1'b0, rd, er);
        do_access(0, 1'b1, 2'd2, 1'b0, 32'h6, 32'hCAFEF00D, 1'b0, rd, er);
        do_access(0, 1'b0, 2'd2, 1'b0, 32'h4, 32'h0, 1'b0, rd, er);
`ifdef DMEM_ALIGN_CHECK_EN
        chk("tp_align_nowrite", rd, 32'h01020304);
`else
        chk("tp_align_forced", rd, 32'hCAFEF00D);
`endif

        // Three wait states: latency/ready checks live in do_access
        do_access(1, 1'b1, 2'd2, 1'b0, 32'h0, 32'hA5A5_0F0F, 1'b0, rd, er);
        do_access(1, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 1'b0, rd, er);
        chk("tp_wait3_load", rd, 32'hA5A5_0F0F);
        keep0 = 32'hA5A5_0F0F;

        // Reset while a store to word 0 is in BUSY
        t_valid[1] = 1'b1; t_we[1] = 1'b1; t_size[1] = 2'd2; t_uns[1] = 1'b0;
        t_addr[1] = 32'h0; t_wdata[1] = 32'h1234_5678;
        @(posedge clk); #1;
        t_valid[1] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("rst_busy_no_rsp", 32'(o_rvld[1]), 32'd0);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_busy_ready", 32'(o_ready[1]), 32'd1);
        chk("rst_busy_no_rsp2", 32'(o_rvld[1]), 32'd0);
        do_access(1, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 1'b0, rd, er);
        chk("rst_busy_word0", rd, keep0);

        // Random traffic against the model, including out-of-range addresses
        for (int k = 0; k < 200; k++) begin
            do_access(int'($urandom_range(0, 1)), 1'($urandom), 2'($urandom), 1'($urandom),
                      32'($urandom_range(0, NBYTE + 3)), $urandom,
                      ($urandom_range(0, 3) == 0), rd, er);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
